// File: rtl/dispense_sequencer.sv
// dispense_sequencer: converts a latched 12-bit amount to BCD by repeated
// subtraction, then walks the non-zero denomination slots from thousands down
// to units. Each slot is lit until its sensor reports an item inserted and is
// then held dark until the item is removed. Both sensor levels are debounced,
// and each wait is bounded by a timeout.
module dispense_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] amount,
    input  logic        abort,
    input  logic [3:0]  slot_sense,
    output logic [3:0]  slot_led,
    output logic [15:0] bcd_digits,
    output logic        digits_vld,
    output logic        busy,
    output logic        done,
    output logic        err_timeout
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CONVERT  = 3'd1,
        S_WAIT_IN  = 3'd2,
        S_WAIT_OUT = 3'd3,
        S_DONE     = 3'd4,
        S_ERR      = 3'd5
    } state_t;

    state_t        state_r;
    logic [11:0]   rem_r;
    logic [3:0]    t_r;
    logic [3:0]    h_r;
    logic [3:0]    d_r;
    logic [3:0]    u_r;
    logic [1:0]    slot_r;
    logic [DW-1:0] deb_r;
    logic [TW-1:0] to_r;

    logic [2:0]    below_s;
    logic [2:0]    next_sel_s;
    logic          sense_s;

    // Highest slot strictly below 'below' holding a non-zero digit.
    // Result is {found, slot}; 'below' = 4 searches all four slots.
    function automatic logic [2:0] pick_slot(input logic [15:0] digs, input logic [2:0] below);
        logic [2:0] sel;
        sel = 3'b000;
        for (int j = 0; j < 4; j++) begin
            if ((j < int'(below)) && (digs[4*j +: 4] != 4'd0)) begin
                sel = {1'b1, 2'(j)};
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    assign bcd_digits = {t_r, h_r, d_r, u_r};

    // Next slot to present: first slot after conversion, otherwise the one below the current slot.
    always_comb begin
        below_s = 3'd4;
        if (state_r == S_CONVERT) begin
            below_s = 3'd4;
        end else begin
            below_s = {1'b0, slot_r};
        end
        next_sel_s = pick_slot(bcd_digits, below_s);
        sense_s    = slot_sense[slot_r];
    end

    // Sequencer state, conversion datapath, debounce/timeout counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            rem_r       <= 12'd0;
            t_r         <= 4'd0;
            h_r         <= 4'd0;
            d_r         <= 4'd0;
            u_r         <= 4'd0;
            slot_r      <= 2'd0;
            deb_r       <= '0;
            to_r        <= '0;
            slot_led    <= 4'd0;
            digits_vld  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
        end else if (abort && (state_r != S_IDLE)) begin
            state_r     <= S_IDLE;
            rem_r       <= 12'd0;
            t_r         <= 4'd0;
            h_r         <= 4'd0;
            d_r         <= 4'd0;
            u_r         <= 4'd0;
            deb_r       <= '0;
            to_r        <= '0;
            slot_led    <= 4'd0;
            digits_vld  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        rem_r      <= amount;
                        t_r        <= 4'd0;
                        h_r        <= 4'd0;
                        d_r        <= 4'd0;
                        u_r        <= 4'd0;
                        digits_vld <= 1'b0;
                        busy       <= 1'b1;
                        state_r    <= S_CONVERT;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_CONVERT: begin
                    if (rem_r >= 12'd1000) begin
                        rem_r <= rem_r - 12'd1000;
                        t_r   <= t_r + 4'd1;
                    end else if (rem_r >= 12'd100) begin
                        rem_r <= rem_r - 12'd100;
                        h_r   <= h_r + 4'd1;
                    end else if (rem_r >= 12'd10) begin
                        rem_r <= rem_r - 12'd10;
                        d_r   <= d_r + 4'd1;
                    end else if (rem_r != 12'd0) begin
                        rem_r <= rem_r - 12'd1;
                        u_r   <= u_r + 4'd1;
                    end else begin
                        digits_vld <= 1'b1;
                        deb_r      <= '0;
                        to_r       <= '0;
                        if (next_sel_s[2]) begin
                            slot_r   <= next_sel_s[1:0];
                            slot_led <= 4'b0001 << next_sel_s[1:0];
                            state_r  <= S_WAIT_IN;
                        end else begin
                            done     <= 1'b1;
                            state_r  <= S_DONE;
                        end
                    end
                end
                S_WAIT_IN: begin
                    if (to_r == TO_LAST) begin
                        slot_led    <= 4'd0;
                        err_timeout <= 1'b1;
                        state_r     <= S_ERR;
                    end else if (sense_s && (deb_r == DEB_LAST)) begin
                        slot_led <= 4'd0;
                        deb_r    <= '0;
                        to_r     <= '0;
                        state_r  <= S_WAIT_OUT;
                    end else if (sense_s) begin
                        deb_r <= deb_r + DEB_ONE;
                        to_r  <= to_r + TO_ONE;
                    end else begin
                        deb_r <= '0;
                        to_r  <= to_r + TO_ONE;
                    end
                end
                S_WAIT_OUT: begin
                    if (to_r == TO_LAST) begin
                        slot_led    <= 4'd0;
                        err_timeout <= 1'b1;
                        state_r     <= S_ERR;
                    end else if (!sense_s && (deb_r == DEB_LAST)) begin
                        deb_r <= '0;
                        to_r  <= '0;
                        if (next_sel_s[2]) begin
                            slot_r   <= next_sel_s[1:0];
                            slot_led <= 4'b0001 << next_sel_s[1:0];
                            state_r  <= S_WAIT_IN;
                        end else begin
                            done     <= 1'b1;
                            state_r  <= S_DONE;
                        end
                    end else if (!sense_s) begin
                        deb_r <= deb_r + DEB_ONE;
                        to_r  <= to_r + TO_ONE;
                    end else begin
                        deb_r <= '0;
                        to_r  <= to_r + TO_ONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                S_ERR: begin
                    slot_led    <= 4'd0;
                    err_timeout <= 1'b1;
                    state_r     <= S_ERR;
                end
                default: begin
                    slot_led    <= 4'd0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    err_timeout <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Self-checking bench for dispense_sequencer. Expected digits, conversion
// latency and slot order come from decimal arithmetic on the amount.
module tb_dispense_sequencer;

    localparam int DEB = 16;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] amount;
    logic        abort;
    logic [3:0]  slot_sense;
    logic [3:0]  slot_led;
    logic [15:0] bcd_digits;
    logic        digits_vld;
    logic        busy;
    logic        done;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    dispense_sequencer #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .amount(amount), .abort(abort),
        .slot_sense(slot_sense), .slot_led(slot_led), .bcd_digits(bcd_digits),
        .digits_vld(digits_vld), .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; amount = 12'd0; slot_sense = 4'd0;
        tick; tick;
        rst_n = 1'b1;
        checks++;
        if ({slot_led, bcd_digits, digits_vld, busy, done, err_timeout} !== 28'd0) begin
            errors++;
            $display("FAIL reset_state got %0h exp 0", {slot_led, bcd_digits, digits_vld, busy, done, err_timeout});
        end
        abort = 1'b1; slot_sense = 4'hF;
        tick;
        abort = 1'b0;
        checks++;
        if ({slot_led, digits_vld, busy, done, err_timeout} !== 8'd0) begin
            errors++;
            $display("FAIL idle_abort_ignored got %0h exp 0", {slot_led, digits_vld, busy, done, err_timeout});
        end
    endtask

    // Full transaction: start, conversion, every non-zero slot inserted then removed, done pulse.
    task automatic run_txn(input logic [11:0] a, input bit ab);
        logic [3:0]  dg [4];
        logic [15:0] exp_bcd;
        logic [3:0]  exp_led;
        int ks[$];
        int ai, n, lat;
        ai = int'(a);
        dg[3] = 4'(ai / 1000);
        dg[2] = 4'((ai / 100) % 10);
        dg[1] = 4'((ai / 10) % 10);
        dg[0] = 4'(ai % 10);
        exp_bcd = {dg[3], dg[2], dg[1], dg[0]};
        n = ai / 1000 + (ai / 100) % 10 + (ai / 10) % 10 + ai % 10;
        for (int k = 3; k >= 0; k--) begin
            if (dg[k] != 4'd0) ks.push_back(k);
        end
        start = 1'b1; amount = a; abort = ab; slot_sense = 4'($urandom);
        tick;
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({busy, digits_vld, bcd_digits, slot_led, done} !== {1'b1, 1'b0, 16'h0000, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL start_accept amt=%0d got %0h exp %0h", a, {busy, digits_vld, bcd_digits, slot_led, done},
                     {1'b1, 1'b0, 16'h0000, 4'h0, 1'b0});
        end
        lat = 1;
        while (digits_vld !== 1'b1 && lat < 40) begin
            slot_sense = 4'($urandom);
            tick;
            lat++;
        end
        checks++;
        if (lat !== n + 2) begin
            errors++;
            $display("FAIL convert_latency amt=%0d got %0d exp %0d", a, lat, n + 2);
        end
        checks++;
        if (bcd_digits !== exp_bcd) begin
            errors++;
            $display("FAIL bcd amt=%0d got %h exp %h", a, bcd_digits, exp_bcd);
        end
        for (int i = 0; i < ks.size(); i++) begin
            int k;
            k = ks[i];
            checks++;
            if ({slot_led, done} !== {4'(1 << k), 1'b0}) begin
                errors++;
                $display("FAIL led_on amt=%0d slot=%0d got %b exp %b", a, k, slot_led, 4'(1 << k));
            end
            for (int c = 0; c < DEB; c++) begin
                slot_sense = 4'($urandom); slot_sense[k] = 1'b1;
                start = 1'($urandom); amount = 12'($urandom);
                tick;
                exp_led = (c == DEB - 1) ? 4'd0 : 4'(1 << k);
                checks++;
                if ({slot_led, busy, done} !== {exp_led, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL insert_debounce amt=%0d slot=%0d cyc=%0d got %b exp %b", a, k, c, slot_led, exp_led);
                end
            end
            for (int c = 0; c < DEB; c++) begin
                slot_sense = 4'($urandom); slot_sense[k] = 1'b0;
                start = 1'($urandom); amount = 12'($urandom);
                tick;
                if (c < DEB - 1) begin
                    checks++;
                    if ({slot_led, done} !== 5'd0) begin
                        errors++;
                        $display("FAIL remove_debounce amt=%0d slot=%0d cyc=%0d got %b exp 0", a, k, c, {slot_led, done});
                    end
                end
            end
        end
        start = 1'b0;
        checks++;
        if ({done, slot_led, busy, digits_vld} !== {1'b1, 4'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL done_pulse amt=%0d got %b exp %b", a, {done, slot_led, busy, digits_vld}, 7'b1000011);
        end
        slot_sense = 4'($urandom);
        tick;
        checks++;
        if ({done, busy, digits_vld, bcd_digits, slot_led, err_timeout} !== {1'b0, 1'b0, 1'b1, exp_bcd, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL back_to_idle amt=%0d got %h exp %h", a, {done, busy, digits_vld, bcd_digits, slot_led, err_timeout},
                     {1'b0, 1'b0, 1'b1, exp_bcd, 4'd0, 1'b0});
        end
    endtask

    task automatic test_debounce;
        int lat;
        start = 1'b1; amount = 12'd3000; slot_sense = 4'd0;
        tick;
        start = 1'b0;
        lat = 0;
        while (digits_vld !== 1'b1 && lat < 40) begin tick; lat++; end
        checks++;
        if (slot_led !== 4'b1000) begin
            errors++;
            $display("FAIL deb_led_on got %b exp 1000", slot_led);
        end
        for (int c = 0; c < 2 * DEB; c++) begin
            slot_sense = 4'($urandom);
            slot_sense[3] = (c != DEB - 1);
            tick;
            checks++;
            if (slot_led !== ((c == 2 * DEB - 1) ? 4'b0000 : 4'b1000)) begin
                errors++;
                $display("FAIL deb_glitch cyc=%0d got %b", c, slot_led);
            end
        end
        checks++;
        if ({busy, done, err_timeout} !== 3'b100) begin
            errors++;
            $display("FAIL deb_wait_out got %b exp 100", {busy, done, err_timeout});
        end
        for (int c = 0; c < DEB; c++) begin
            slot_sense = 4'($urandom); slot_sense[3] = 1'b0;
            tick;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL deb_done got %b exp 1", done);
        end
        tick;
    endtask

    task automatic test_timeout;
        int ai, k, lat;
        ai = $urandom_range(1, 4095);
        k = (ai >= 1000) ? 3 : (ai >= 100) ? 2 : (ai >= 10) ? 1 : 0;
        start = 1'b1; amount = 12'(ai); slot_sense = 4'd0;
        tick;
        start = 1'b0;
        lat = 0;
        while (digits_vld !== 1'b1 && lat < 40) begin tick; lat++; end
        checks++;
        if (slot_led !== 4'(1 << k)) begin
            errors++;
            $display("FAIL tmo_led_on amt=%0d got %b exp %b", ai, slot_led, 4'(1 << k));
        end
        for (int c = 1; c < TMO; c++) begin
            slot_sense = 4'($urandom); slot_sense[k] = 1'b0;
            tick;
            checks++;
            if ({err_timeout, slot_led} !== {1'b0, 4'(1 << k)}) begin
                errors++;
                $display("FAIL tmo_early cyc=%0d got %b", c, {err_timeout, slot_led});
            end
        end
        tick;
        checks++;
        if ({err_timeout, slot_led, busy, done} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL tmo_err got %b exp 1000010", {err_timeout, slot_led, busy, done});
        end
        repeat (5) begin slot_sense = 4'($urandom); tick; end
        checks++;
        if ({err_timeout, slot_led, busy} !== {1'b1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL tmo_sticky got %b exp 100001", {err_timeout, slot_led, busy});
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++;
        if ({err_timeout, slot_led, busy, done, digits_vld} !== 8'd0) begin
            errors++;
            $display("FAIL tmo_abort got %b exp 0", {err_timeout, slot_led, busy, done, digits_vld});
        end
    endtask

    task automatic test_abort_reset;
        int lat;
        start = 1'b1; amount = 12'd1111; slot_sense = 4'd0;
        tick;
        start = 1'b0;
        lat = 0;
        while (digits_vld !== 1'b1 && lat < 40) begin tick; lat++; end
        slot_sense = 4'b1000;
        repeat (DEB) tick;
        slot_sense = 4'b0000;
        repeat (5) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++;
        if ({slot_led, bcd_digits, digits_vld, busy, done, err_timeout} !== 28'd0) begin
            errors++;
            $display("FAIL abort_wait_out got %h exp 0", {slot_led, bcd_digits, digits_vld, busy, done, err_timeout});
        end
        run_txn(12'($urandom), 1'b0);
        start = 1'b1; amount = 12'd4095;
        tick;
        start = 1'b0;
        repeat (4) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        checks++;
        if ({slot_led, bcd_digits, digits_vld, busy, done, err_timeout} !== 28'd0) begin
            errors++;
            $display("FAIL reset_mid_convert got %h exp 0", {slot_led, bcd_digits, digits_vld, busy, done, err_timeout});
        end
        run_txn(12'($urandom), 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 16; i++) begin
            run_txn(12'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) begin
                abort = 1'b1;
                tick;
                abort = 1'b0;
                checks++;
                if ({digits_vld, busy, done} !== 3'b100) begin
                    errors++;
                    $display("FAIL idle_abort_keeps_vld got %b exp 100", {digits_vld, busy, done});
                end
            end
        end
    endtask

    initial begin
        test_reset;
        run_txn(12'd2507, 1'b0);
        run_txn(12'd0, 1'b0);
        run_txn(12'd4095, 1'b0);
        test_debounce;
        test_timeout;
        test_abort_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
